// File: rtl/counter_scheduler.sv
// -----------------------------------------------------------------------------
// counter_scheduler
//
// Shares one external CNT_W-bit up-counter between NUM_REQ requesters. Each
// requester asks for an interval of req_len ticks. Requests are granted round-
// robin. For each service the block clears the counter, enables it until the
// requested count is reached, and then pulses done with a status. A shadow copy
// of the expected count is kept, and any disagreement with the counter ends the
// service with a mismatch status and sets a sticky error flag.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-low reset (also clears the counter)
//   req          per-requester service request (level, sampled in IDLE only)
//   req_len      requester i's length in bits [i*CNT_W +: CNT_W]
//   abort        ends the current service early (level)
//   cnt_value    present value of the shared counter
//   cnt_reset    active-high clear to the counter
//   cnt_enable   increment enable to the counter
//   gnt          one-hot grant, held from CLEAR through the last RUN cycle
//   busy         scheduler is not idle
//   done         one-cycle completion pulse
//   done_id      index of the completed requester, valid with done
//   done_status  00 ok, 01 aborted, 10 counter mismatch; valid with done
//   err_sticky   set on any mismatch, cleared only by reset
// -----------------------------------------------------------------------------
module counter_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int CNT_W   = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    input  logic                     abort,
    input  logic [CNT_W-1:0]         cnt_value,
    output logic                     cnt_reset,
    output logic                     cnt_enable,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [1:0]               done_status,
    output logic                     err_sticky
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_ABORT    = 2'b01;
    localparam logic [1:0] STATUS_MISMATCH = 2'b10;

    // (base + offset) modulo NUM_REQ, for offsets in 0..NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int              offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    state_t               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     shadow_q, shadow_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 done_q, done_d;
    logic [ID_W-1:0]      done_id_q, done_id_d;
    logic [1:0]           done_status_q, done_status_d;
    logic                 err_sticky_q, err_sticky_d;

    logic                 pick_valid;
    logic [ID_W-1:0]      pick_id;
    logic [CNT_W-1:0]     pick_len;
    logic                 mismatch;
    logic                 at_len;

    // Round-robin pick: scanning offsets from highest to lowest and letting each
    // hit overwrite the previous one leaves the smallest offset from rr_q.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_add(rr_q, k)]) begin
                pick_valid = 1'b1;
                pick_id    = wrap_add(rr_q, k);
            end
        end
    end

    assign pick_len = req_len[int'(pick_id) * CNT_W +: CNT_W];

    assign mismatch   = (cnt_value != shadow_q);
    assign at_len     = (cnt_value == len_q);
    assign cnt_enable = (state_q == RUN) && !at_len && !abort && !mismatch;

    // The counter is cleared while the scheduler is held in reset as well as in
    // CLEAR, so both always start a service from zero together.
    assign cnt_reset  = !reset || (state_q == CLEAR);
    assign busy       = (state_q != IDLE);

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign done_status = done_status_q;
    assign err_sticky  = err_sticky_q;

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        len_d         = len_q;
        shadow_d      = shadow_q;
        rr_d          = rr_q;
        gnt_d         = gnt_q;
        done_d        = 1'b0;
        done_id_d     = done_id_q;
        done_status_d = done_status_q;
        err_sticky_d  = err_sticky_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_id;
                    len_d   = pick_len;
                    gnt_d   = NUM_REQ'(1) << pick_id;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                shadow_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (cnt_enable) shadow_d = shadow_q + CNT_W'(1);
                if (mismatch || abort || at_len) begin
                    state_d   = DONE;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    // Mismatch outranks abort, which outranks normal completion.
                    if (mismatch) begin
                        done_status_d = STATUS_MISMATCH;
                        err_sticky_d  = 1'b1;
                    end else if (abort) begin
                        done_status_d = STATUS_ABORT;
                    end else begin
                        done_status_d = STATUS_OK;
                    end
                end
            end
            DONE: begin
                // Start the next scan just past the requester just served.
                rr_d    = wrap_add(id_q, 1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!reset) begin
            state_q       <= IDLE;
            id_q          <= '0;
            len_q         <= '0;
            shadow_q      <= '0;
            rr_q          <= '0;
            gnt_q         <= '0;
            done_q        <= 1'b0;
            done_id_q     <= '0;
            done_status_q <= STATUS_OK;
            err_sticky_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            len_q         <= len_d;
            shadow_q      <= shadow_d;
            rr_q          <= rr_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            done_id_q     <= done_id_d;
            done_status_q <= done_status_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for counter_scheduler. Contains a model of the shared counter, a
// service-level reference model of the scheduler that is compared against the
// DUT every cycle, and directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_counter_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] req_len;
    logic                     abort;
    logic [CNT_W-1:0]         cnt_value;
    logic                     cnt_reset;
    logic                     cnt_enable;
    logic [NUM_REQ-1:0]       gnt;
    logic                     busy;
    logic                     done;
    logic [ID_W-1:0]          done_id;
    logic [1:0]               done_status;
    logic                     err_sticky;

    counter_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_len     (req_len),
        .abort       (abort),
        .cnt_value   (cnt_value),
        .cnt_reset   (cnt_reset),
        .cnt_enable  (cnt_enable),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .done_status (done_status),
        .err_sticky  (err_sticky)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit stall    = 1'b0;
    int en_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Shared counter: clear dominates, otherwise count on enable. When stall is
    // set it refuses to leave the value 1, which must provoke a mismatch.
    always @(posedge clk) begin
        if (cnt_reset)
            cnt_value <= '0;
        else if (cnt_enable && !(stall && cnt_value == 4'd1))
            cnt_value <= cnt_value + 4'd1;
    end

    // Number of enabled cycles since the counter was last cleared.
    always @(negedge clk) begin
        if (cnt_reset)      en_count = 0;
        else if (cnt_enable) en_count++;
    end

    // Reference model, tracked per service as cycle stamps:
    // a service picked at the end of cycle c has its clear cycle at c+1, runs
    // from c+2 and ends with done in the cycle after its terminating run cycle.
    bit m_valid  = 1'b0;
    bit m_svc    = 1'b0;
    bit m_err    = 1'b0;
    int m_id     = 0;
    int m_len    = 0;
    int m_rr     = 0;
    int m_t_clear = 0;
    int m_t_done = -1;
    int m_ticks  = 0;
    int m_status = 0;
    int m_pick   = 0;
    int m_i      = 0;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_valid  = 1'b1;
            m_svc    = 1'b0;
            m_rr     = 0;
            m_err    = 1'b0;
            m_t_done = -1;
        end else if (m_valid) begin
            if (!m_svc) begin
                m_pick = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    m_i = (m_rr + k) % NUM_REQ;
                    if (m_pick < 0 && req[m_i]) m_pick = m_i;
                end
                if (m_pick >= 0) begin
                    m_svc     = 1'b1;
                    m_id      = m_pick;
                    m_len     = int'(req_len[m_pick*CNT_W +: CNT_W]);
                    m_t_clear = cyc;
                    m_t_done  = -1;
                    m_ticks   = 0;
                end
            end else if (m_t_done == cyc - 1) begin
                m_svc = 1'b0;
                m_rr  = (m_id + 1) % NUM_REQ;
            end else if (m_t_done < 0 && cyc - 1 > m_t_clear) begin
                // A run cycle just ended; m_ticks is how many ticks were granted.
                if (int'(cnt_value) != m_ticks) begin
                    m_status = 2; m_err = 1'b1; m_t_done = cyc;
                end else if (abort) begin
                    m_status = 1; m_t_done = cyc;
                end else if (int'(cnt_value) == m_len) begin
                    m_status = 0; m_t_done = cyc;
                end else begin
                    m_ticks++;
                end
            end
        end
    end

    logic [NUM_REQ-1:0] exp_gnt;
    logic               exp_done;
    logic               exp_cnt_reset;
    logic               exp_en;

    always @(negedge clk) begin
        if (m_valid) begin
            exp_gnt       = (m_svc && m_t_done < 0) ? 4'(1 << m_id) : 4'b0;
            exp_done      = m_svc && (m_t_done == cyc);
            exp_cnt_reset = !reset || (m_svc && cyc == m_t_clear);
            exp_en        = m_svc && m_t_done < 0 && cyc > m_t_clear
                            && int'(cnt_value) == m_ticks && !abort
                            && int'(cnt_value) != m_len;
            check("cyc_gnt",        gnt,        exp_gnt);
            check("cyc_busy",       busy,       m_svc);
            check("cyc_done",       done,       exp_done);
            check("cyc_cnt_reset",  cnt_reset,  exp_cnt_reset);
            check("cyc_cnt_enable", cnt_enable, exp_en);
            check("cyc_err_sticky", err_sticky, m_err);
            if (exp_done) begin
                check("cyc_done_id",     done_id,     m_id);
                check("cyc_done_status", done_status, m_status);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    // Present a request for exactly one IDLE cycle; k is that cycle's index.
    task automatic start_req(input logic [NUM_REQ-1:0] mask, output int k);
        req = mask;
        k   = cyc;
        tick();
        req = '0;
    endtask

    task automatic wait_done(input int max_cycles, output int at);
        at = -1;
        for (int i = 0; i < max_cycles; i++) begin
            if (done === 1'b1) begin
                at = cyc;
                break;
            end
            tick();
        end
        if (at < 0) check("done_timeout", done, 1);
    endtask

    task automatic set_len(input int idx, input int len);
        req_len[idx*CNT_W +: CNT_W] = CNT_W'(len);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int at;
        int prev;
        reset   = 1'b0;
        req     = '0;
        req_len = '0;
        abort   = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_gnt",       gnt,        0);
        check("rst_busy",      busy,       0);
        check("rst_done",      done,       0);
        check("rst_err",       err_sticky, 0);
        check("rst_cnt_reset", cnt_reset,  1);
        reset = 1'b1;

        // Single service, len 3: clear at 1, enable 2..4, done at 6.
        set_len(0, 3);
        start_req(4'b0001, k);
        check("t1_gnt_clear",  gnt,       4'b0001);
        check("t1_cnt_reset",  cnt_reset, 1);
        wait_done(20, at);
        check("t1_latency",    at - k,      6);
        check("t1_done_id",    done_id,     0);
        check("t1_status",     done_status, 2'b00);
        check("t1_en_cycles",  en_count,    3);
        check("t1_cnt_final",  cnt_value,   3);
        tick();

        // All four requesting, len 1 each: rotation 0,1,2,3,0 every 5 cycles.
        do_reset(1);
        for (int i = 0; i < NUM_REQ; i++) set_len(i, 1);
        req  = 4'b1111;
        k    = cyc;
        prev = k - 1;
        for (int n = 0; n < 5; n++) begin
            wait_done(20, at);
            check("t2_done_id", done_id, n % NUM_REQ);
            check("t2_spacing", at - prev, (n == 0) ? 5 : 5);
            prev = at;
            if (n == 4) req = '0;
            tick();
        end
        tick();

        // len 0 on requester 2: done at 3, no enable.
        set_len(2, 0);
        start_req(4'b0100, k);
        wait_done(20, at);
        check("t3_latency",   at - k,      3);
        check("t3_done_id",   done_id,     2);
        check("t3_en_cycles", en_count,    0);
        tick();

        // Max length: counter reaches all-ones, done at 18.
        set_len(2, 15);
        start_req(4'b0100, k);
        wait_done(40, at);
        check("t3_max_latency", at - k,      18);
        check("t3_max_status",  done_status, 2'b00);
        check("t3_max_cnt",     cnt_value,   15);
        check("t3_max_en",      en_count,    15);
        tick();

        // Abort in the third RUN cycle of a len-10 service.
        set_len(0, 10);
        start_req(4'b0001, k);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_done",       done,        1);
        check("t4_latency",    cyc - k,     5);
        check("t4_status",     done_status, 2'b01);
        check("t4_cnt_final",  cnt_value,   2);
        check("t4_err",        err_sticky,  0);
        tick();

        // Counter stalls at 1 with len 5: mismatch, sticky error.
        stall = 1'b1;
        set_len(1, 5);
        start_req(4'b0010, k);
        wait_done(20, at);
        check("t5_latency", at - k,      5);
        check("t5_status",  done_status, 2'b10);
        check("t5_done_id", done_id,     1);
        tick();
        stall = 1'b0;
        check("t5_err",     err_sticky,  1);
        set_len(1, 2);
        start_req(4'b0010, k);
        wait_done(20, at);
        check("t5_clean_status", done_status, 2'b00);
        check("t5_err_kept",     err_sticky,  1);
        tick();

        // Reset in mid-RUN of requester 3 (rr pointer is 2 here).
        set_len(3, 8);
        start_req(4'b1000, k);
        check("t6_gnt3", gnt, 4'b1000);
        tick();
        tick();
        tick();
        reset = 1'b0;
        req   = 4'b1001;
        tick();
        check("t6_gnt_rst",       gnt,        0);
        check("t6_busy_rst",      busy,       0);
        check("t6_done_rst",      done,       0);
        check("t6_cnt_reset_rst", cnt_reset,  1);
        check("t6_err_rst",       err_sticky, 0);
        tick();
        reset = 1'b1;
        tick();
        check("t6_restart_gnt", gnt, 4'b0001);
        req = '0;
        wait_done(30, at);
        check("t6_done_id", done_id,     0);
        check("t6_status",  done_status, 2'b00);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Sequences a single shared CNT_W-bit up-counter (active-high reset, enable-to-increment, wraps 1111->0000) between NUM_REQ requesters.
- Each requester asks for a timed interval of req_len counter ticks.
- The block grants round-robin, clears the counter, enables it until the requested count is reached, then reports completion.
- It also cross-checks the counter's value against an internal shadow and flags any mismatch.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, width of the shared counter and of each length field.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-low.
- req  input  NUM_REQ  per-requester service request, level.
- req_len  input  NUM_REQ*CNT_W  requester i's length in bits [i*CNT_W +: CNT_W].
- abort  input  1  terminate the current service early.
- cnt_value  input  CNT_W  present value of the shared counter.
- cnt_reset  output  1  active-high clear to the counter.
- cnt_enable  output  1  increment enable to the counter.
- gnt  output  NUM_REQ  one-hot grant, held for the whole service.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- done_id  output  clog2(NUM_REQ)  index of the completed requester, valid with done.
- done_status  output  2  valid with done: 00 ok, 01 aborted, 10 counter mismatch.
- err_sticky  output  1  set on any mismatch, cleared only by reset.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, gnt=0, done=0, done_id=0, done_status=00, err_sticky=0, cnt_enable=0, rr pointer=0, shadow=0, len_q=0.
- cnt_reset is combinationally 1 whenever reset==0, so the counter clears together with the scheduler. Reset mid-service drops everything with no done pulse.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If req!=0, pick the first set bit scanning from the rr pointer upward, modulo NUM_REQ.
  - Latch its id and len_q = its req_len, then go to CLEAR.
  - req is sampled only in IDLE.
- CLEAR (1 cycle):
  - gnt[id]=1, cnt_reset=1, cnt_enable=0, shadow<=0. Go to RUN.
- RUN:
  - gnt held.
  - cnt_enable = (cnt_value != len_q) && !abort && !mismatch, where mismatch = (cnt_value != shadow).
  - shadow increments on every cycle cnt_enable=1.
  - If cnt_value==len_q, go to DONE with status 00.
  - If abort, go to DONE with status 01; abort takes priority over normal completion in the same cycle.
  - If mismatch, go to DONE with status 10 and set err_sticky; mismatch takes priority over abort.
  - Abort in CLEAR is honoured on the next RUN cycle, since it is level-sampled.
- DONE (1 cycle):
  - done=1, done_id=id, done_status per the cause, gnt=0, cnt_enable=0.
  - rr pointer <= id+1 mod NUM_REQ. Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0 gives CLEAR at cycle 1, RUN from cycle 2, and done at cycle 3+len_q.
  - cnt_enable is high for exactly len_q cycles.
- len_q=0: RUN lasts one cycle with cnt_enable=0, and done appears at cycle 3.
- Max len (2^CNT_W-1): the counter reaches all-ones and never wraps under the scheduler.
- Withdrawing req during service has no effect; the service completes. A requester still asserting req after its done is eligible again, but rotation gives the others priority first.
- Back-to-back services: there is one IDLE cycle between DONE and the next CLEAR, so the minimum period is 4+len_q cycles.
- gnt is always one-hot or zero; busy=1 in CLEAR, RUN and DONE.

Test Plan:
- Reset low for 2 cycles, then req=0001, len0=3 -> gnt=0001 at cycles 1-5, cnt_reset=1 at cycle 1, cnt_enable=1 at cycles 2-4, done=1 at cycle 6 with done_id=0 and status 00.
- req=1111 held, all lengths=1 -> grants in order 0,1,2,3,0; each done 4 cycles after its service starts, with a 5-cycle period.
- len=0 on requester 2 alone -> done at cycle 3 with done_id=2, cnt_enable never high; len=15 -> cnt_value reaches 1111 and done arrives with status 00.
- abort pulsed in the third RUN cycle with len=10 -> done the next cycle with status 01, counter stops at 2, err_sticky stays 0.
- Bench forces cnt_value to stall at 1 with len=5 -> mismatch detected, done with status 10, err_sticky=1 and kept through later clean services until reset.
- reset asserted in mid-RUN -> next cycle state IDLE, gnt=0, no done, cnt_reset=1; after release, a pending req restarts from rr pointer 0.
